present_engine: RTL and testbench
=================================

Name: present_engine

Overview:
- Next-generation PRESENT block cipher core: one iterative round datapath serves both encryption and decryption.
- Key width is parametrised (80 or 128 bit); valid/ready handshakes replace the load/done pair on input and output.
- Caches the expanded final round key, so back-to-back decryptions under the same key skip the key pre-expansion pass.
- Sits behind the bus wrapper as the cipher engine; one block in flight at a time.

Parameters:
- KEY_WIDTH, 80, key size; legal values 80 and 128 only (elaboration error otherwise).
- NUM_ROUNDS, 31, round count; fixed by the algorithm, exposed for reduced-round debug builds (legal range 1..31).

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request present
- in_ready  out  1  engine can accept a request
- in_data  in  64  plaintext (enc) or ciphertext (dec)
- in_key  in  KEY_WIDTH  cipher key, sampled only when in_key_new=1
- in_key_new  in  1  load in_key with this request; invalidates key cache
- in_mode  in  1  0=encrypt, 1=decrypt
- out_valid  out  1  result present, held until accepted
- out_ready  in  1  consumer accepts result
- out_data  out  64  result block
- busy  out  1  high in any state other than IDLE, or while out_valid=1
- done  out  1  one-cycle pulse on the cycle out_valid rises

Behaviour:
- Reset, asynchronous, reset_n=0:
  - state=IDLE; in_ready=0 while in reset.
  - out_valid=0, out_data=0, busy=0, done=0.
  - Key register=0, cached K_last=0, cache_valid=0.
- Reset mid-operation aborts the operation. No output is produced for the aborted request.
- Accept rule: handshake when in_valid && in_ready; in_ready = (state==IDLE) && !out_valid.
  - On accept: latch in_data, in_mode.
  - If in_key_new: latch in_key and clear cache_valid.
  - No key was ever loaded: the zero key is used (defined behaviour).
- Key schedule, round counter i=1..NUM_ROUNDS; round key = key[KEY_WIDTH-1 -: 64].
  - Step, 80-bit: rotl 61; S on [79:76]; [19:15] ^= i.
  - Step, 128-bit: rotl 61; S on [127:124] and [123:120]; [66:62] ^= i.
  - Inverse step: [..] ^= i, then S^-1 on the same nibble(s), then rotr 61.
- States:
  - IDLE: accept. Encrypt -> ENC.
  - IDLE: decrypt with cache_valid=1 -> DEC, key loaded from K_last.
  - IDLE: decrypt with cache_valid=0 -> KEXP.
  - KEXP: NUM_ROUNDS cycles of forward key steps only; then store K_last, set cache_valid=1, -> DEC.
  - ENC: each cycle state = P(S(state ^ K_i)), then key step, i++. After round NUM_ROUNDS, out_data = state ^ K_last and out_valid=1, -> IDLE.
  - DEC: first cycle state ^= K_last. Then per cycle, i from NUM_ROUNDS down to 1: state = S^-1(P^-1(state)) ^ K_{i} after the inverse key step. After i=1 -> out_valid=1, -> IDLE.
  - An ENC pass also sets K_last/cache_valid as a side effect.
- Latency, accept edge to out_valid:
  - Encrypt: NUM_ROUNDS+1 cycles (32).
  - Decrypt, cached key: NUM_ROUNDS+2 cycles (33).
  - Decrypt, uncached key: 2*NUM_ROUNDS+2 cycles (64).
- Output: out_data stable while out_valid && !out_ready. out_valid falls the cycle after the out_ready handshake; in_ready rises that same cycle.
- in_key_new=1 with an unchanged key value still invalidates the cache.

Decomposition:
- present_pkg holds:
  - SBOX and SBOX_INV 16x4 constants.
  - Mode encodings ENC=0, DEC=1.
  - State enum {IDLE, KEXP, ENC, DEC}.
  - Functions p_layer, p_layer_inv, s_layer, s_layer_inv (64-bit).
- Sub-module present_key_step: combinational forward/inverse key update, parametrised by KEY_WIDTH. Inputs: key, round index, direction.

Test Plan:
- KEY_WIDTH=80, key 0, pt 0, enc -> out_data 5579C1387B228445 at 32 cycles; done one pulse.
- KEY_WIDTH=80, key FFFFFFFFFFFFFFFFFFFF, pt FFFFFFFFFFFFFFFF, enc -> 3333DCD3213210D2. Then decrypt that ciphertext with in_key_new=0 -> FFFFFFFFFFFFFFFF at 33 cycles (cache hit).
- KEY_WIDTH=80, key FFFF..FF, decrypt E72C46C0F5945049 with in_key_new=1 -> 0000000000000000 at 64 cycles; an immediate second decrypt with the same key takes 33 cycles.
- KEY_WIDTH=128, key 0, pt 0, enc -> 96DB702A2E6900AF; decrypt back -> 0.
- Backpressure: out_ready=0 for 10 cycles -> out_data/out_valid held, in_ready=0, in_valid ignored. out_ready=1 -> next cycle in_ready=1.
- reset_n pulsed low at round 15 of decrypt -> no out_valid; cache_valid cleared. A following decrypt takes 64 cycles and gives the correct plaintext.

Source files
------------

// File: rtl/present_pkg.sv
// PRESENT cipher constants, FSM state encoding and the 64-bit substitution /
// permutation layers shared by the round datapath and the key schedule.
package present_pkg;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef enum logic [1:0] {IDLE, KEXP, ENC, DEC} state_t;

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };
    localparam logic [3:0] SBOX_INV [16] = '{
        4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
    };

    // Bit j of the state moves to position 16*j mod 63; bit 63 stays put.
    function automatic logic [5:0] p_pos(input int j);
        return (j == 63) ? 6'd63 : 6'((j * 16) % 63);
    endfunction

    function automatic logic [63:0] p_layer(input logic [63:0] s);
        logic [63:0] o;
        o = '0;
        for (int j = 0; j < 64; j++) o[p_pos(j)] = s[6'(j)];
        return o;
    endfunction

    function automatic logic [63:0] p_layer_inv(input logic [63:0] s);
        logic [63:0] o;
        o = '0;
        for (int j = 0; j < 64; j++) o[6'(j)] = s[p_pos(j)];
        return o;
    endfunction

    function automatic logic [63:0] s_layer(input logic [63:0] s);
        logic [63:0] o;
        o = '0;
        for (int n = 0; n < 16; n++) o[6'(4 * n) +: 4] = SBOX[s[6'(4 * n) +: 4]];
        return o;
    endfunction

    function automatic logic [63:0] s_layer_inv(input logic [63:0] s);
        logic [63:0] o;
        o = '0;
        for (int n = 0; n < 16; n++) o[6'(4 * n) +: 4] = SBOX_INV[s[6'(4 * n) +: 4]];
        return o;
    endfunction

endpackage

// File: rtl/present_engine_if.sv
// Request/response handshake bundle between the bus wrapper (master) and the
// PRESENT cipher engine (slave).
interface present_engine_if #(
    parameter int KEY_WIDTH = 80
);
    logic                 in_valid;
    logic                 in_ready;
    logic [63:0]          in_data;
    logic [KEY_WIDTH-1:0] in_key;
    logic                 in_key_new;
    logic                 in_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [63:0]          out_data;
    logic                 busy;
    logic                 done;

    modport master (
        output in_valid, in_data, in_key, in_key_new, in_mode, out_ready,
        input  in_ready, out_valid, out_data, busy, done
    );

    modport slave (
        input  in_valid, in_data, in_key, in_key_new, in_mode, out_ready,
        output in_ready, out_valid, out_data, busy, done
    );
endinterface

// File: rtl/present_key_step.sv
// One PRESENT key-register update, forward (encrypt direction) or its exact
// inverse, for an 80- or 128-bit key register.
module present_key_step
    import present_pkg::*;
#(
    parameter int KEY_WIDTH = 80
) (
    input  logic [KEY_WIDTH-1:0] key,
    input  logic [4:0]           round,
    input  logic                 inverse,
    output logic [KEY_WIDTH-1:0] key_next
);
    localparam int CNT_LSB  = (KEY_WIDTH == 128) ? 62 : 15;
    localparam int NIBBLES  = (KEY_WIDTH == 128) ? 2 : 1;

    logic [KEY_WIDTH-1:0] fwd;
    logic [KEY_WIDTH-1:0] unmixed;

    always_comb begin
        fwd = {key[KEY_WIDTH-62:0], key[KEY_WIDTH-1:KEY_WIDTH-61]};
        for (int n = 0; n < NIBBLES; n++) begin
            fwd[KEY_WIDTH-1-4*n -: 4] = SBOX[fwd[KEY_WIDTH-1-4*n -: 4]];
        end
        fwd[CNT_LSB +: 5] = fwd[CNT_LSB +: 5] ^ round;

        // Undo the forward step in reverse order: counter, S-box, then rotation.
        unmixed = key;
        unmixed[CNT_LSB +: 5] = unmixed[CNT_LSB +: 5] ^ round;
        for (int n = 0; n < NIBBLES; n++) begin
            unmixed[KEY_WIDTH-1-4*n -: 4] = SBOX_INV[unmixed[KEY_WIDTH-1-4*n -: 4]];
        end

        key_next = inverse ? {unmixed[60:0], unmixed[KEY_WIDTH-1:61]} : fwd;
    end
endmodule

// File: rtl/present_engine.sv
// Iterative PRESENT engine: one round per cycle for encryption and decryption,
// caching the final round key so repeat decryptions skip key pre-expansion.
module present_engine
    import present_pkg::*;
#(
    parameter int KEY_WIDTH  = 80,
    parameter int NUM_ROUNDS = 31
) (
    input  logic            clk,
    input  logic            reset_n,
    present_engine_if.slave bus
);
    generate
        if ((KEY_WIDTH != 80 && KEY_WIDTH != 128) || NUM_ROUNDS < 1 || NUM_ROUNDS > 31) begin : g_bad_params
            $error("present_engine: KEY_WIDTH must be 80 or 128 and NUM_ROUNDS 1..31");
        end
    endgenerate

    localparam logic [5:0] LAST_ROUND  = 6'(NUM_ROUNDS);
    localparam logic [5:0] FINAL_ROUND = 6'(NUM_ROUNDS + 1);

    state_t               state_reg;
    logic [5:0]           round_reg;
    logic [63:0]          data_reg;
    logic [63:0]          out_data_reg;
    logic [KEY_WIDTH-1:0] key_reg;
    logic [KEY_WIDTH-1:0] round_key_reg;
    logic [KEY_WIDTH-1:0] k_last_reg;
    logic                 cache_valid_reg;
    logic                 out_valid_reg;
    logic                 done_reg;

    logic                 ready;
    logic                 accept;
    logic [KEY_WIDTH-1:0] accept_key;
    logic [KEY_WIDTH-1:0] step_key;
    logic [63:0]          rk_cur;
    logic [63:0]          rk_prev;

    assign ready      = reset_n && (state_reg == IDLE) && !out_valid_reg;
    assign accept     = bus.in_valid && ready;
    assign accept_key = bus.in_key_new ? bus.in_key : key_reg;
    assign rk_cur     = round_key_reg[KEY_WIDTH-1 -: 64];
    assign rk_prev    = step_key[KEY_WIDTH-1 -: 64];

    assign bus.in_ready  = ready;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.busy      = (state_reg != IDLE) || out_valid_reg;
    assign bus.done      = done_reg;

    present_key_step #(.KEY_WIDTH(KEY_WIDTH)) u_key_step (
        .key      (round_key_reg),
        .round    (round_reg[4:0]),
        .inverse  (state_reg == DEC),
        .key_next (step_key)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            round_reg       <= '0;
            data_reg        <= '0;
            out_data_reg    <= '0;
            key_reg         <= '0;
            round_key_reg   <= '0;
            k_last_reg      <= '0;
            cache_valid_reg <= 1'b0;
            out_valid_reg   <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (out_valid_reg && bus.out_ready) out_valid_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        data_reg <= bus.in_data;
                        if (bus.in_key_new) begin
                            key_reg         <= bus.in_key;
                            cache_valid_reg <= 1'b0;
                        end
                        if (bus.in_mode == MODE_ENC) begin
                            round_key_reg <= accept_key;
                            round_reg     <= 6'd1;
                            state_reg     <= ENC;
                        end else if (cache_valid_reg && !bus.in_key_new) begin
                            round_key_reg <= k_last_reg;
                            round_reg     <= FINAL_ROUND;
                            state_reg     <= DEC;
                        end else begin
                            round_key_reg <= accept_key;
                            round_reg     <= 6'd1;
                            state_reg     <= KEXP;
                        end
                    end
                end

                KEXP: begin
                    round_key_reg <= step_key;
                    if (round_reg == LAST_ROUND) begin
                        k_last_reg      <= step_key;
                        cache_valid_reg <= 1'b1;
                        round_reg       <= FINAL_ROUND;
                        state_reg       <= DEC;
                    end else begin
                        round_reg <= round_reg + 6'd1;
                    end
                end

                ENC: begin
                    if (round_reg == FINAL_ROUND) begin
                        out_data_reg    <= data_reg ^ rk_cur;
                        out_valid_reg   <= 1'b1;
                        done_reg        <= 1'b1;
                        k_last_reg      <= round_key_reg;
                        cache_valid_reg <= 1'b1;
                        state_reg       <= IDLE;
                    end else begin
                        data_reg      <= p_layer(s_layer(data_reg ^ rk_cur));
                        round_key_reg <= step_key;
                        round_reg     <= round_reg + 6'd1;
                    end
                end

                DEC: begin
                    // FINAL_ROUND is the whitening cycle; round 0 means plaintext is ready.
                    if (round_reg == FINAL_ROUND) begin
                        data_reg  <= data_reg ^ rk_cur;
                        round_reg <= LAST_ROUND;
                    end else if (round_reg == 6'd0) begin
                        out_data_reg  <= data_reg;
                        out_valid_reg <= 1'b1;
                        done_reg      <= 1'b1;
                        state_reg     <= IDLE;
                    end else begin
                        data_reg      <= s_layer_inv(p_layer_inv(data_reg)) ^ rk_prev;
                        round_key_reg <= step_key;
                        round_reg     <= round_reg - 6'd1;
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_present_engine.sv
// Directed and random transactions against 80- and 128-bit engines, checked
// against a round-key-table PRESENT reference model and a latency/cache model.
module tb_present_engine;
    localparam int NR = 31;
    localparam logic [127:0] KMASK80 = {48'd0, {80{1'b1}}};
    localparam logic [3:0] SBT [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n;
    logic         sel;
    logic         vld;
    logic         knew_d;
    logic         mode_d;
    logic         oready;
    logic [63:0]  din_d;
    logic [127:0] key_d;

    int n_checks = 0;
    int n_fail   = 0;
    logic [127:0] mkey [2];
    bit           mcache [2];

    present_engine_if #(.KEY_WIDTH(80))  bus80 ();
    present_engine_if #(.KEY_WIDTH(128)) bus128 ();

    present_engine #(.KEY_WIDTH(80), .NUM_ROUNDS(NR)) dut80 (
        .clk(clk), .reset_n(reset_n), .bus(bus80)
    );
    present_engine #(.KEY_WIDTH(128), .NUM_ROUNDS(NR)) dut128 (
        .clk(clk), .reset_n(reset_n), .bus(bus128)
    );

    assign bus80.in_valid   = vld & ~sel;
    assign bus80.in_data    = din_d;
    assign bus80.in_key     = key_d[79:0];
    assign bus80.in_key_new = knew_d;
    assign bus80.in_mode    = mode_d;
    assign bus80.out_ready  = oready;
    assign bus128.in_valid   = vld & sel;
    assign bus128.in_data    = din_d;
    assign bus128.in_key     = key_d;
    assign bus128.in_key_new = knew_d;
    assign bus128.in_mode    = mode_d;
    assign bus128.out_ready  = oready;

    wire        obs_ready = sel ? bus128.in_ready  : bus80.in_ready;
    wire        obs_valid = sel ? bus128.out_valid : bus80.out_valid;
    wire [63:0] obs_data  = sel ? bus128.out_data  : bus80.out_data;
    wire        obs_busy  = sel ? bus128.busy      : bus80.busy;
    wire        obs_done  = sel ? bus128.done      : bus80.done;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [3:0] sbinv(input logic [3:0] x);
        for (int j = 0; j < 16; j++) if (SBT[j] == x) return 4'(j);
        return 4'd0;
    endfunction

    function automatic logic [63:0] sbox_all(input logic [63:0] s, input bit inv);
        logic [63:0] o = '0;
        logic [3:0]  x;
        for (int n = 0; n < 16; n++) begin
            x = 4'(s >> (4 * n));
            o = o | (64'(inv ? sbinv(x) : SBT[x]) << (4 * n));
        end
        return o;
    endfunction

    function automatic logic [63:0] perm(input logic [63:0] s, input bit inv);
        logic [63:0] o = '0;
        int d;
        for (int j = 0; j < 64; j++) begin
            d = (j == 63) ? 63 : (j * 16) % 63;
            if (!inv) o = o | (((s >> j) & 64'd1) << d);
            else      o = o | (((s >> d) & 64'd1) << j);
        end
        return o;
    endfunction

    function automatic logic [127:0] sub_nibble(input logic [127:0] k, input int pos);
        logic [3:0] n;
        n = 4'(k >> pos);
        return (k & ~(128'hF << pos)) | (128'(SBT[n]) << pos);
    endfunction

    function automatic logic [63:0] ref_cipher(input logic [127:0] key, input int kw,
                                               input bit dec, input logic [63:0] din);
        logic [63:0]  rk [1:NR+1];
        logic [127:0] k;
        logic [127:0] mask;
        logic [63:0]  s;
        mask = (kw == 128) ? {128{1'b1}} : KMASK80;
        k = key & mask;
        for (int r = 1; r <= NR + 1; r++) begin
            rk[r] = 64'(k >> (kw - 64));
            k = ((k << 61) | (k >> (kw - 61))) & mask;
            k = sub_nibble(k, kw - 4);
            if (kw == 128) k = sub_nibble(k, kw - 8);
            k = k ^ (128'(r) << ((kw == 128) ? 62 : 15));
        end
        if (!dec) begin
            s = din;
            for (int r = 1; r <= NR; r++) s = perm(sbox_all(s ^ rk[r], 1'b0), 1'b0);
            s = s ^ rk[NR+1];
        end else begin
            s = din ^ rk[NR+1];
            for (int r = NR; r >= 1; r--) s = sbox_all(perm(s, 1'b1), 1'b1) ^ rk[r];
        end
        return s;
    endfunction

    // ---------------- one transaction ----------------
    task automatic txn(input bit s, input logic [63:0] din, input logic [127:0] k,
                       input bit knew, input bit m, input int hold, input bit has_kat,
                       input logic [63:0] kat, input string tag, output logic [63:0] res);
        int kw, lat, exp_lat, w;
        logic [63:0] got;
        kw = s ? 128 : 80;
        if (knew) begin
            mkey[s]   = s ? k : (k & KMASK80);
            mcache[s] = 1'b0;
        end
        exp_lat = (m == 1'b0) ? NR + 1 : (mcache[s] ? NR + 2 : 2 * NR + 2);
        res = ref_cipher(mkey[s], kw, m, din);

        sel = s;
        #1;
        w = 0;
        while (obs_ready !== 1'b1 && w < 200) begin @(posedge clk); #1; w++; end
        chk({tag, ".ready_before"}, 64'(obs_ready), 64'd1);
        din_d = din; key_d = k; knew_d = knew; mode_d = m; oready = (hold == 0); vld = 1'b1;
        @(posedge clk); #1;
        vld = 1'b0; knew_d = 1'b0;
        chk({tag, ".busy_after_accept"}, 64'(obs_busy), 64'd1);
        chk({tag, ".ready_after_accept"}, 64'(obs_ready), 64'd0);

        lat = 0;
        while (obs_valid !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
        got = obs_data;
        chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, ".data"}, got, res);
        chk({tag, ".done_pulse"}, 64'(obs_done), 64'd1);
        if (has_kat) chk({tag, ".known_answer"}, got, kat);
        mcache[s] = 1'b1;

        if (hold > 0) begin
            din_d = ~din; mode_d = ~m; vld = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                chk({tag, ".hold_valid"}, 64'(obs_valid), 64'd1);
                chk({tag, ".hold_data"}, obs_data, res);
                chk({tag, ".hold_ready"}, 64'(obs_ready), 64'd0);
                chk({tag, ".hold_done"}, 64'(obs_done), 64'd0);
            end
            vld = 1'b0; oready = 1'b1;
        end
        @(posedge clk); #1;
        chk({tag, ".valid_drop"}, 64'(obs_valid), 64'd0);
        chk({tag, ".ready_rise"}, 64'(obs_ready), 64'd1);
        chk({tag, ".done_clear"}, 64'(obs_done), 64'd0);
        chk({tag, ".busy_clear"}, 64'(obs_busy), 64'd0);
        $display("txn %s kw=%0d mode=%0d key_new=%0d in=%h out=%h lat=%0d",
                 tag, kw, m, knew, din, got, lat);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r, r2, pt;
        logic [127:0] kk;
        bit seen;
        reset_n = 1'b0; sel = 1'b0; vld = 1'b0; knew_d = 1'b0; mode_d = 1'b0;
        oready = 1'b1; din_d = '0; key_d = '0;
        mkey[0] = '0; mkey[1] = '0; mcache[0] = 1'b0; mcache[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.in_ready80", 64'(bus80.in_ready), 64'd0);
        chk("reset.in_ready128", 64'(bus128.in_ready), 64'd0);
        chk("reset.out_valid", 64'(bus80.out_valid), 64'd0);
        chk("reset.out_data", bus80.out_data, 64'd0);
        chk("reset.busy", 64'(bus80.busy), 64'd0);
        chk("reset.done", 64'(bus80.done), 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset.in_ready", 64'(bus80.in_ready), 64'd1);

        // Zero key is used before any key is loaded.
        txn(1'b0, 64'd0, 128'd0, 1'b0, 1'b0, 0, 1'b1, 64'h5579C1387B228445, "enc80_zero", r);
        kk = 128'hFFFF_FFFF_FFFF_FFFF_FFFF;
        txn(1'b0, 64'hFFFFFFFFFFFFFFFF, kk, 1'b1, 1'b0, 0, 1'b1, 64'h3333DCD3213210D2, "enc80_ones", r);
        txn(1'b0, r, 128'd0, 1'b0, 1'b1, 0, 1'b1, 64'hFFFFFFFFFFFFFFFF, "dec80_cached", r2);
        txn(1'b0, 64'hE72C46C0F5945049, kk, 1'b1, 1'b1, 0, 1'b1, 64'd0, "dec80_uncached", r);
        txn(1'b0, 64'hE72C46C0F5945049, kk, 1'b0, 1'b1, 0, 1'b1, 64'd0, "dec80_repeat", r);
        txn(1'b0, 64'hE72C46C0F5945049, kk, 1'b1, 1'b1, 0, 1'b1, 64'd0, "dec80_same_key_new", r);

        txn(1'b1, 64'd0, 128'd0, 1'b0, 1'b0, 0, 1'b1, 64'h96DB702A2E6900AF, "enc128_zero", r);
        txn(1'b1, r, 128'd0, 1'b0, 1'b1, 0, 1'b1, 64'd0, "dec128_back", r2);

        txn(1'b0, 64'h0123456789ABCDEF, 128'h1234, 1'b1, 1'b0, 10, 1'b0, 64'd0, "backpressure", r);

        // Abort a cached decryption mid-way with an asynchronous reset.
        sel = 1'b0; #1;
        din_d = r; knew_d = 1'b0; mode_d = 1'b1; oready = 1'b1; vld = 1'b1;
        @(posedge clk); #1;
        vld = 1'b0;
        repeat (18) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort.out_valid", 64'(bus80.out_valid), 64'd0);
        chk("abort.busy", 64'(bus80.busy), 64'd0);
        chk("abort.in_ready", 64'(bus80.in_ready), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        mkey[0] = '0; mkey[1] = '0; mcache[0] = 1'b0; mcache[1] = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            seen = seen | bus80.out_valid;
        end
        chk("abort.no_output", 64'(seen), 64'd0);
        txn(1'b0, 64'hE72C46C0F5945049, kk, 1'b1, 1'b1, 0, 1'b1, 64'd0, "dec80_after_abort", r);

        for (int t = 0; t < 14; t++) begin
            bit s, m, kn;
            s  = 1'($urandom_range(0, 1));
            m  = 1'($urandom_range(0, 1));
            kn = ($urandom_range(0, 3) == 0);
            pt = {$urandom, $urandom};
            kk = {$urandom, $urandom, $urandom, $urandom};
            txn(s, pt, kk, kn, m, 0, 1'b0, 64'd0, "random", r);
            if (m == 1'b0 && $urandom_range(0, 1) == 1)
                txn(s, r, kk, 1'b0, 1'b1, 0, 1'b1, pt, "random_roundtrip", r2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
